// File: rtl/map_port_arbiter.sv
// Arbitrates the single map BRAM read port between the renderer and physics engine.
// Optional statistics counters are enabled with MAP_ARB_STATS_EN.
module map_port_arbiter #(
    parameter int ADDR_W       = 9,
    parameter int DATA_W       = 29,
    parameter int MEM_LAT      = 1,
    parameter int STARVE_LIMIT = 4
) (
    input  logic              pixel_clk,
    input  logic              reset,
    input  logic              vde,
    input  logic              r_req,
    input  logic [ADDR_W-1:0] r_addr,
    output logic              r_gnt,
    output logic              r_rvalid,
    output logic [DATA_W-1:0] r_rdata,
    input  logic              p_req,
    input  logic [ADDR_W-1:0] p_addr,
    output logic              p_gnt,
    output logic              p_rvalid,
    output logic [DATA_W-1:0] p_rdata,
    output logic              mem_en,
    output logic [ADDR_W-1:0] mem_addr,
    input  logic [DATA_W-1:0] mem_rdata,
    output logic              p_starved
`ifdef MAP_ARB_STATS_EN
    ,
    input  logic              stat_clr,
    output logic [15:0]       stat_r_stall,
    output logic [15:0]       stat_p_force
`endif
);

    localparam logic [7:0] AGE_MAX = 8'(STARVE_LIMIT);

    logic [7:0]         age;
    logic               force_p;
    logic [MEM_LAT-1:0] vld_pipe;
    logic [MEM_LAT-1:0] own_pipe;   // 1 = physics owns the in-flight read

    always_comb begin
        r_gnt   = 1'b0;
        p_gnt   = 1'b0;
        force_p = 1'b0;
        if (!reset) begin
            if (p_req && age == AGE_MAX) begin
                p_gnt   = 1'b1;
                force_p = 1'b1;
            end else if (vde) begin
                if (r_req)      r_gnt = 1'b1;
                else if (p_req) p_gnt = 1'b1;
            end else begin
                if (p_req)      p_gnt = 1'b1;
                else if (r_req) r_gnt = 1'b1;
            end
        end
    end

    assign mem_en   = r_gnt | p_gnt;
    assign mem_addr = r_gnt ? r_addr : (p_gnt ? p_addr : '0);

    always_ff @(posedge pixel_clk or posedge reset) begin
        if (reset) begin
            age       <= '0;
            p_starved <= 1'b0;
        end else begin
            p_starved <= force_p;
            if (p_gnt || !p_req)
                age <= '0;
            else if (age < AGE_MAX)
                age <= age + 8'd1;
        end
    end

    // Tag pipe tracks the owner of each read so data returns in grant order.
    always_ff @(posedge pixel_clk or posedge reset) begin
        if (reset) begin
            vld_pipe <= '0;
            own_pipe <= '0;
            r_rvalid <= 1'b0;
            p_rvalid <= 1'b0;
            r_rdata  <= '0;
            p_rdata  <= '0;
        end else begin
            vld_pipe[0] <= mem_en;
            own_pipe[0] <= p_gnt;
            for (int i = 1; i < MEM_LAT; i++) begin
                vld_pipe[i] <= vld_pipe[i-1];
                own_pipe[i] <= own_pipe[i-1];
            end
            r_rvalid <= vld_pipe[MEM_LAT-1] && !own_pipe[MEM_LAT-1];
            p_rvalid <= vld_pipe[MEM_LAT-1] &&  own_pipe[MEM_LAT-1];
            if (vld_pipe[MEM_LAT-1] && !own_pipe[MEM_LAT-1])
                r_rdata <= mem_rdata;
            if (vld_pipe[MEM_LAT-1] && own_pipe[MEM_LAT-1])
                p_rdata <= mem_rdata;
        end
    end

`ifdef MAP_ARB_STATS_EN
    always_ff @(posedge pixel_clk or posedge reset) begin
        if (reset) begin
            stat_r_stall <= '0;
            stat_p_force <= '0;
        end else if (stat_clr) begin
            stat_r_stall <= '0;
            stat_p_force <= '0;
        end else begin
            if (r_req && !r_gnt && stat_r_stall != 16'hFFFF)
                stat_r_stall <= stat_r_stall + 16'd1;
            if (force_p && stat_p_force != 16'hFFFF)
                stat_p_force <= stat_p_force + 16'd1;
        end
    end
`endif

endmodule
